// File: rtl/robo_paddle_pkg.sv
// Shared definitions for the paddle controller: FSM encodings and playfield defaults.
// The defaults match the ball engine and renderer so all three agree on geometry.
package robo_paddle_pkg;

    typedef enum logic [1:0] {
        CENTER = 2'd0,
        WAIT   = 2'd1,
        TRACK  = 2'd2
    } robo_state_t;

    localparam int DEF_SCREENHEIGHT = 480;
    localparam int DEF_PADDLESIZE   = 48;
    localparam int SPEED_W          = 4;

endpackage

// File: rtl/robo_stepper.sv
// Combinational step computation: dead-zone, accelerating no-overshoot step, playfield clamp.
// Pure logic, zero latency; no handshake, result is consumed on the frame strobe.
// Backpressure: none, outputs are always valid for the current inputs.
module robo_stepper
    import robo_paddle_pkg::*;
#(
    parameter int W            = 10,
    parameter int DEADZONE     = 2,
    parameter int MAXSTEP      = 4,
    parameter int PADDLESIZE   = DEF_PADDLESIZE,
    parameter int SCREENHEIGHT = DEF_SCREENHEIGHT
) (
    input  logic [W-1:0]       paddle_y,
    input  logic [W-1:0]       target,
    input  logic [SPEED_W-1:0] speed,
    input  logic               last_dir,
    output logic [W-1:0]       next_y,
    output logic [SPEED_W-1:0] next_speed,
    output logic               dir,
    output logic               moved
);

    localparam logic [W:0] LO = (W+1)'(PADDLESIZE / 2);
    localparam logic [W:0] HI = (W+1)'(SCREENHEIGHT - PADDLESIZE / 2);
    localparam logic [W:0] DZ = (W+1)'(DEADZONE);

    logic signed [W:0]   err;
    logic [W:0]          mag;
    logic [W:0]          step;
    logic [W:0]          raw;
    logic [W:0]          clamped;
    logic                up;
    logic [SPEED_W-1:0]  spd;

    always_comb begin
        err     = $signed({1'b0, target}) - $signed({1'b0, paddle_y});
        up      = ~err[W];
        mag     = err[W] ? $unsigned(-err) : $unsigned(err);
        // A reversal restarts acceleration from the slowest step.
        spd     = (up != last_dir) ? SPEED_W'(1) : speed;
        step    = ((W+1)'(spd) < mag) ? (W+1)'(spd) : mag;
        raw     = up ? ({1'b0, paddle_y} + step) : ({1'b0, paddle_y} - step);
        clamped = (raw < LO) ? LO : ((raw > HI) ? HI : raw);

        next_y     = paddle_y;
        next_speed = SPEED_W'(1);
        dir        = last_dir;
        moved      = 1'b0;
        if (mag > DZ) begin
            next_y     = clamped[W-1:0];
            next_speed = (spd >= SPEED_W'(MAXSTEP)) ? SPEED_W'(MAXSTEP) : spd + 1'b1;
            dir        = up;
            moved      = (clamped[W-1:0] != paddle_y);
        end
    end

endmodule

// File: rtl/robo_paddle.sv
// AI opponent paddle: CENTER/WAIT/TRACK FSM with reaction delay, stepping once per frame strobe.
// Latency: outputs update one clk after a sampling edge with advance=1 and enable=1.
// Backpressure: none; enable=0 freezes every register and advance is ignored.
module robo_paddle
    import robo_paddle_pkg::*;
#(
    parameter int W            = 10,
    parameter int SCREENHEIGHT = DEF_SCREENHEIGHT,
    parameter int PADDLESIZE   = DEF_PADDLESIZE,
    parameter int MAXSTEP      = 4,
    parameter int DEADZONE     = 2,
    parameter int REACTION     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         advance,
    input  logic         enable,
    input  logic         approaching,
    input  logic [W-1:0] ball_y,
    output logic [W-1:0] paddle_y,
    output logic         moving,
    output logic         tracking
);

    localparam int           RW  = (REACTION < 2) ? 1 : $clog2(REACTION);
    localparam logic [W-1:0] MID = W'(SCREENHEIGHT / 2);

    robo_state_t        state, state_nx;
    logic [SPEED_W-1:0] speed, speed_in, speed_nx, step_speed;
    logic               last_dir, dir_nx, step_dir, step_moved;
    logic [RW-1:0]      react_cnt, react_nx;
    logic [W-1:0]       target, step_y, paddle_nx;
    logic               moving_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CENTER;
            speed     <= SPEED_W'(1);
            last_dir  <= 1'b0;
            react_cnt <= '0;
            paddle_y  <= MID;
            moving    <= 1'b0;
            tracking  <= 1'b0;
        end else if (advance && enable) begin
            state     <= state_nx;
            speed     <= speed_nx;
            last_dir  <= dir_nx;
            react_cnt <= react_nx;
            paddle_y  <= paddle_nx;
            moving    <= moving_nx;
            tracking  <= (state_nx == TRACK);
        end
    end

    always_comb begin
        state_nx = state;
        react_nx = react_cnt;
        case (state)
            CENTER: begin
                if (approaching) begin
                    if (REACTION == 0) begin
                        state_nx = TRACK;
                    end else begin
                        state_nx = WAIT;
                        react_nx = RW'(REACTION - 1);
                    end
                end
            end
            WAIT: begin
                if (!approaching)          state_nx = CENTER;
                else if (react_cnt == '0)  state_nx = TRACK;
                else                       react_nx = react_cnt - 1'b1;
            end
            TRACK: begin
                if (!approaching) state_nx = CENTER;
            end
            default: state_nx = CENTER;
        endcase

        // The step always uses the state being entered this frame.
        target   = (state_nx == TRACK) ? ball_y : MID;
        speed_in = (state_nx != state) ? SPEED_W'(1) : speed;

        if (state_nx == WAIT) begin
            paddle_nx = paddle_y;
            speed_nx  = speed_in;
            dir_nx    = last_dir;
            moving_nx = 1'b0;
        end else begin
            paddle_nx = step_y;
            speed_nx  = step_speed;
            dir_nx    = step_dir;
            moving_nx = step_moved;
        end
    end

    robo_stepper #(
        .W            (W),
        .DEADZONE     (DEADZONE),
        .MAXSTEP      (MAXSTEP),
        .PADDLESIZE   (PADDLESIZE),
        .SCREENHEIGHT (SCREENHEIGHT)
    ) u_stepper (
        .paddle_y   (paddle_y),
        .target     (target),
        .speed      (speed_in),
        .last_dir   (last_dir),
        .next_y     (step_y),
        .next_speed (step_speed),
        .dir        (step_dir),
        .moved      (step_moved)
    );

endmodule

// File: tb/tb_robo_paddle.sv
// Directed bench for robo_paddle: frame-by-frame vector table plus reset, freeze and clamp sequences.
module tb_robo_paddle;

    logic       clk = 1'b0;
    logic       reset;
    logic       advance;
    logic       enable;
    logic       approaching;
    logic [9:0] ball_y;
    logic [9:0] paddle_y;
    logic       moving;
    logic       tracking;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       en;
        logic       ap;
        logic [9:0] ball;
        logic [9:0] y;
        logic       mv;
        logic       trk;
    } vec_t;

    vec_t tbl[$];

    robo_paddle dut (
        .clk         (clk),
        .reset       (reset),
        .advance     (advance),
        .enable      (enable),
        .approaching (approaching),
        .ball_y      (ball_y),
        .paddle_y    (paddle_y),
        .moving      (moving),
        .tracking    (tracking)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic en, input logic ap, input int ball,
                                input int y, input logic mv, input logic trk);
        vec_t v;
        v.en = en; v.ap = ap; v.ball = 10'(ball); v.y = 10'(y); v.mv = mv; v.trk = trk;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input int y, input logic mv, input logic trk);
        chk({name, ".paddle_y"}, int'(paddle_y), y);
        chk({name, ".moving"},   int'(moving),   int'(mv));
        chk({name, ".tracking"}, int'(tracking), int'(trk));
    endtask

    // One frame: inputs and a one-cycle advance pulse; outputs observed at the following negedge.
    task automatic do_frame(input logic en, input logic ap, input logic [9:0] b);
        @(negedge clk);
        enable = en; approaching = ap; ball_y = b; advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
    endtask

    initial begin
        int max_y;

        reset = 1'b1; advance = 1'b0; enable = 1'b1; approaching = 1'b0; ball_y = 10'd240;

        // Reaction delay then acceleration towards ball_y=400, then exact landing at speed 4.
        for (int i = 0; i < 4; i++) add(1, 1, 400, 240, 0, 0);
        add(1, 1, 400, 241, 1, 1);
        add(1, 1, 400, 243, 1, 1);
        add(1, 1, 400, 246, 1, 1);
        add(1, 1, 400, 250, 1, 1);
        add(1, 1, 400, 254, 1, 1);
        add(1, 1, 400, 258, 1, 1);
        add(1, 1, 261, 261, 1, 1);
        add(1, 1, 261, 261, 0, 1);
        // Walk to 299, then dead-zone edge and single-line step around 300.
        add(1, 1, 300, 262, 1, 1);
        add(1, 1, 300, 264, 1, 1);
        for (int y = 267; y <= 299; y += 4) add(1, 1, 300, y, 1, 1);
        add(1, 1, 300, 299, 0, 1);
        add(1, 1, 303, 300, 1, 1);
        add(1, 1, 302, 300, 0, 1);
        add(1, 1, 303, 301, 1, 1);
        // Up to 350, then recede back to centre.
        add(1, 1, 350, 303, 1, 1);
        add(1, 1, 350, 306, 1, 1);
        for (int y = 310; y <= 350; y += 4) add(1, 1, 350, y, 1, 1);
        add(1, 0, 350, 349, 1, 0);
        add(1, 0, 350, 347, 1, 0);
        add(1, 0, 350, 344, 1, 0);
        for (int y = 340; y >= 240; y -= 4) add(1, 0, 350, y, 1, 0);
        add(1, 0, 350, 240, 0, 0);
        // Freeze mid-WAIT with approaching dropped; resume must finish the remaining count.
        add(1, 1, 100, 240, 0, 0);
        add(1, 1, 100, 240, 0, 0);
        for (int i = 0; i < 20; i++) add(0, 0, 0, 240, 0, 0);
        add(1, 1, 100, 240, 0, 0);
        add(1, 1, 100, 240, 0, 0);
        add(1, 1, 100, 239, 1, 1);
        add(1, 1, 100, 237, 1, 1);

        // Power-on reset: visible before any clock edge, held for 3 clocks.
        #2;
        chk_out("reset_async", 240, 0, 0);
        repeat (3) @(posedge clk);
        #1 chk_out("reset_held", 240, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_frame(tbl[i].en, tbl[i].ap, tbl[i].ball);
            chk_out($sformatf("row%0d", i), int'(tbl[i].y), tbl[i].mv, tbl[i].trk);
        end

        // Reset mid-TRACK, asserted between clock edges.
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk_out("reset_mid_track", 240, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_frame(1, 1, 100);
        chk_out("after_reset_wait", 240, 0, 0);

        // Clamp at the bottom: never beyond 456, pinned with moving=0.
        max_y = 0;
        for (int i = 0; i < 100; i++) begin
            do_frame(1, 1, 10'd479);
            if (int'(paddle_y) > max_y) max_y = int'(paddle_y);
        end
        chk("clamp_bottom_max", max_y, 456);
        chk_out("clamp_bottom", 456, 0, 1);

        for (int i = 0; i < 150; i++) do_frame(1, 1, 10'd0);
        chk_out("clamp_top", 24, 0, 1);

        for (int i = 0; i < 150; i++) do_frame(1, 1, 10'd1000);
        chk_out("clamp_beyond_screen", 456, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
